tai_gray_rx: RTL and testbench

- Receive side of the inter-board TAI link: samples the 10-bit Gray-coded TAI bus driven by a master quabo when the local pad buffers are in input mode.
- Synchronizes, de-glitches, Gray-decodes and sequence-checks the value.
- Delivers a binary TAI value, a one-cycle tick per accepted second, a lock indication and error reporting to the local timestamp logic.

---
 rtl/tai_pkg.sv | 12 +
 rtl/gray_to_bin.sv | 20 ++
 rtl/tai_gray_rx.sv | 166 ++++++++++++++++
 tb/tb_tai_gray_rx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tai_pkg.sv
// rtl/tai_pkg.sv - shared TAI link constants and receiver state encoding
package tai_pkg;

    localparam int TAI_WIDTH     = 10;
    localparam int ERR_CNT_WIDTH = 16;

    typedef enum logic {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } tai_state_e;

endpackage

// File: rtl/gray_to_bin.sv
// rtl/gray_to_bin.sv - combinational Gray to binary decoder
module gray_to_bin #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Running XOR from the MSB down; a local accumulator keeps the chain in one process.
    always_comb begin
        logic [WIDTH-1:0] acc;
        acc = '0;
        acc[WIDTH-1] = gray[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            acc[i] = acc[i+1] ^ gray[i];
        end
        bin = acc;
    end

endmodule

// File: rtl/tai_gray_rx.sv
// rtl/tai_gray_rx.sv - TAI link receiver: sync, de-glitch, Gray decode, sequence check
module tai_gray_rx
    import tai_pkg::*;
#(
    parameter int WIDTH          = TAI_WIDTH,
    parameter int STABLE_CYCLES  = 8,
    parameter int LOCK_COUNT     = 3,
    parameter int TIMEOUT_CYCLES = 150000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [WIDTH-1:0]         tai_gray_in,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         tai_bin,
    output logic                     tai_valid,
    output logic                     tai_tick,
    output logic                     locked,
    output logic                     err_jump,
    output logic                     err_timeout,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    localparam int STAB_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int SEQ_W  = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    logic [WIDTH-1:0]  sync1, sync2, cand, prev_gray, new_bin, gray_diff;
    logic [STAB_W-1:0] stab_cnt;
    logic              have_prev;
    logic              accept, seq_ok, one_bit, timeout_hit;

    tai_state_e        state, state_nxt;
    logic [SEQ_W-1:0]  seq_cnt, seq_nxt;
    logic [TO_W-1:0]   to_cnt, to_nxt;
    logic              jump_nxt, tout_nxt;

    gray_to_bin #(.WIDTH(WIDTH)) u_dec (
        .gray (cand),
        .bin  (new_bin)
    );

    assign accept      = en && (stab_cnt == STAB_MAX) && (!have_prev || (cand != prev_gray));
    assign gray_diff   = cand ^ prev_gray;
    assign one_bit     = (gray_diff != '0) && ((gray_diff & (gray_diff - 1'b1)) == '0);
    assign seq_ok      = have_prev && (new_bin == WIDTH'(tai_bin + 1'b1)) && one_bit;
    assign timeout_hit = (to_cnt == TO_LAST);
    assign locked      = (state == LOCKED);

    always_comb begin
        state_nxt = state;
        seq_nxt   = seq_cnt;
        to_nxt    = to_cnt;
        jump_nxt  = 1'b0;
        tout_nxt  = 1'b0;
        if (!en) begin
            state_nxt = ACQUIRE;
            seq_nxt   = '0;
            to_nxt    = '0;
        end else begin
            case (state)
                ACQUIRE: begin
                    if (accept) begin
                        if (seq_ok) begin
                            if (int'(seq_cnt) + 1 == LOCK_COUNT) begin
                                state_nxt = LOCKED;
                                seq_nxt   = '0;
                                to_nxt    = '0;
                            end else begin
                                seq_nxt = seq_cnt + 1'b1;
                            end
                        end else begin
                            seq_nxt = '0;
                        end
                    end
                end
                LOCKED: begin
                    // An accept on the timeout edge still counts as a timely update.
                    if (accept) begin
                        to_nxt = '0;
                        if (!seq_ok) begin
                            jump_nxt  = 1'b1;
                            state_nxt = ACQUIRE;
                            seq_nxt   = '0;
                        end
                    end else if (timeout_hit) begin
                        tout_nxt  = 1'b1;
                        state_nxt = ACQUIRE;
                        seq_nxt   = '0;
                        to_nxt    = '0;
                    end else begin
                        to_nxt = to_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = ACQUIRE;
                    seq_nxt   = '0;
                    to_nxt    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ACQUIRE;
            seq_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            seq_cnt <= seq_nxt;
            to_cnt  <= to_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= '0;
            sync2       <= '0;
            cand        <= '0;
            stab_cnt    <= '0;
            prev_gray   <= '0;
            have_prev   <= 1'b0;
            tai_bin     <= '0;
            tai_valid   <= 1'b0;
            tai_tick    <= 1'b0;
            err_jump    <= 1'b0;
            err_timeout <= 1'b0;
            err_count   <= '0;
        end else begin
            sync1 <= tai_gray_in;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand     <= sync2;
                stab_cnt <= '0;
            end else if (stab_cnt != STAB_MAX) begin
                stab_cnt <= stab_cnt + 1'b1;
            end

            tai_tick <= accept;
            if (accept) begin
                tai_bin   <= new_bin;
                prev_gray <= cand;
                have_prev <= 1'b1;
                tai_valid <= 1'b1;
            end
            // Disabling forgets the previous value so re-enable starts a fresh acquisition.
            if (!en) begin
                have_prev <= 1'b0;
                tai_valid <= 1'b0;
            end

            err_jump    <= jump_nxt;
            err_timeout <= tout_nxt;
            if (clr_err) begin
                err_count <= '0;
            end else if ((jump_nxt || tout_nxt) && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tai_gray_rx.sv
// tb/tb_tai_gray_rx.sv - directed-vector bench for tai_gray_rx
module tb_tai_gray_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [9:0]  tai_gray_in;
    logic        clr_err;
    logic [9:0]  tai_bin;
    logic        tai_valid;
    logic        tai_tick;
    logic        locked;
    logic        err_jump;
    logic        err_timeout;
    logic [15:0] err_count;

    int vectors     = 0;
    int miscompares = 0;
    int ticks       = 0;
    int jumps       = 0;
    int touts       = 0;

    tai_gray_rx #(
        .WIDTH          (10),
        .STABLE_CYCLES  (4),
        .LOCK_COUNT     (3),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .tai_gray_in (tai_gray_in),
        .clr_err     (clr_err),
        .tai_bin     (tai_bin),
        .tai_valid   (tai_valid),
        .tai_tick    (tai_tick),
        .locked      (locked),
        .err_jump    (err_jump),
        .err_timeout (err_timeout),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] gray(input int b);
        logic [9:0] v;
        v = 10'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (tai_tick)    ticks++;
        if (err_jump)    jumps++;
        if (err_timeout) touts++;
    endtask

    task automatic hold(input logic [9:0] g, input int n);
        tai_gray_in = g;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int first_tick;
        int t0;
        rst = 1'b1; en = 1'b1; clr_err = 1'b0;
        tai_gray_in = 10'h007;
        for (int k = 0; k < 3; k++) step();
        check("rst_bin",   tai_bin, 0);
        check("rst_valid", tai_valid, 0);
        check("rst_tick",  tai_tick, 0);
        check("rst_lock",  locked, 0);
        check("rst_errs",  {err_jump, err_timeout}, 0);
        check("rst_cnt",   err_count, 0);

        rst = 1'b0;
        ticks = 0;
        first_tick = 0;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (tai_tick && first_tick == 0) first_tick = e;
        end
        check("first_tick_edge", first_tick, 7);
        check("first_tick_once", ticks, 1);
        check("first_bin",   tai_bin, 5);
        check("first_valid", tai_valid, 1);
        check("first_lock",  locked, 0);

        hold(10'h007, 88);
        hold(10'h005, 100);
        check("lock_after6", locked, 0);
        hold(10'h004, 100);
        check("lock_after7", locked, 0);
        hold(10'h00C, 100);
        check("lock_after8", locked, 1);
        check("ticks_5to8",  ticks, 4);
        check("errs_5to8",   jumps + touts, 0);
        check("bin_8",       tai_bin, 8);

        en = 1'b0;
        t0 = ticks;
        hold(gray(1020), 20);
        check("dis_ticks", ticks - t0, 0);
        check("dis_bin",   tai_bin, 8);
        check("dis_valid", tai_valid, 0);
        check("dis_lock",  locked, 0);
        en = 1'b1;
        hold(gray(1020), 20);
        check("reen_bin", tai_bin, 1020);
        hold(gray(1021), 20);
        hold(gray(1022), 20);
        check("lock_1022", locked, 0);
        hold(10'h200, 20);
        check("lock_1023", locked, 1);
        hold(10'h000, 20);
        check("wrap_lock", locked, 1);
        check("wrap_bin",  tai_bin, 0);
        check("wrap_cnt",  err_count, 0);
        for (int v = 1; v <= 10; v++) hold(gray(v), 20);
        check("run_lock", locked, 1);
        check("run_bin",  tai_bin, 10);

        jumps = 0;
        hold(10'h00A, 20);
        check("jump_pulses", jumps, 1);
        check("jump_lock",   locked, 0);
        check("jump_bin",    tai_bin, 12);
        check("jump_cnt",    err_count, 1);

        t0 = ticks;
        hold(10'h00B, 2);
        hold(10'h00A, 30);
        check("glitch_ticks", ticks - t0, 0);
        check("glitch_bin",   tai_bin, 12);

        hold(gray(13), 20);
        hold(gray(14), 20);
        tai_gray_in = gray(15);
        t0 = ticks;
        for (int k = 0; k < 20 && ticks == t0; k++) step();
        check("lock15_tick", ticks - t0, 1);
        check("lock15_lock", locked, 1);
        touts = 0;
        for (int k = 0; k < 999; k++) step();
        check("pre_to_lock", locked, 1);
        check("pre_to_none", touts, 0);
        step();
        check("to_pulse", err_timeout, 1);
        check("to_lock",  locked, 0);
        check("to_cnt",   err_count, 2);
        check("to_bin",   tai_bin, 15);
        step();
        check("to_once", err_timeout, 0);

        hold(gray(16), 20);
        hold(gray(17), 20);
        hold(gray(18), 20);
        check("lock18", locked, 1);
        hold(gray(25), 6);
        check("pre_clr_jump", err_jump, 0);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("clr_jump", err_jump, 1);
        check("clr_cnt",  err_count, 0);
        check("clr_lock", locked, 0);
        check("clr_bin",  tai_bin, 25);
        step();
        check("clr_cnt_after", err_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
